// File: rtl/openhmc_rf_master.sv
// -----------------------------------------------------------------------------
// openhmc_rf_master
// Sequences single accesses onto the openHMC register-file port from a
// valid/ready command channel, and returns read data and status on a
// valid/ready response channel. Only one RF access is outstanding at a time.
// Strobes are one-cycle pulses, and read and write strobes are never high together.
//
// Optional build macro: OPENHMC_RF_MASTER_ADDR_CHECK_EN
//   When defined, illegal accesses are rejected locally on acceptance.
//   Rejected writes: 0x0, 0x1, 0x3-0x7, 0x9-0xC. Rejected reads: 0x8.
//   A rejected request goes straight to the response with rsp_invalid = 1,
//   and no RF strobe is issued.
//
// Ports
//   clk_hmc, res_n_hmc        clock, asynchronous active-low reset
//   req_*                     command channel (valid/ready, write flag, addr, data)
//   rsp_*                     response channel (valid/ready, rdata, invalid, timeout)
//   rf_*                      register-file port (address, strobes, data, complete)
//   stat_timeout_cnt          saturating count of timed-out accesses
//   stat_invalid_cnt          saturating count of invalid-address responses
// -----------------------------------------------------------------------------
module openhmc_rf_master #(
    parameter int unsigned HMC_RF_AWIDTH  = 4,
    parameter int unsigned HMC_RF_WWIDTH  = 64,
    parameter int unsigned HMC_RF_RWIDTH  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk_hmc,
    input  logic                     res_n_hmc,
    // command channel
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [HMC_RF_AWIDTH-1:0] req_addr,
    input  logic [HMC_RF_WWIDTH-1:0] req_wdata,
    // response channel
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [HMC_RF_RWIDTH-1:0] rsp_rdata,
    output logic                     rsp_invalid,
    output logic                     rsp_timeout,
    // register-file port
    output logic [HMC_RF_AWIDTH-1:0] rf_address,
    output logic                     rf_read_en,
    output logic                     rf_write_en,
    output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
    input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
    input  logic                     rf_invalid_address,
    input  logic                     rf_access_complete,
    // statistics
    output logic [7:0]               stat_timeout_cnt,
    output logic [7:0]               stat_invalid_cnt
);

    localparam int unsigned TCNT_W = 16;
    localparam int unsigned STAT_W = 8;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state;
    logic                is_write;
    logic [TCNT_W-1:0]   tcnt;

    // Saturating increment for the statistics counters
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

`ifdef OPENHMC_RF_MASTER_ADDR_CHECK_EN
    // Local legality check of the access being accepted
    function automatic logic addr_rejected(input logic wr,
                                           input logic [HMC_RF_AWIDTH-1:0] a);
        if (wr)
            return (a <= HMC_RF_AWIDTH'(12)) && (a != HMC_RF_AWIDTH'(2)) &&
                   (a != HMC_RF_AWIDTH'(8));
        return a == HMC_RF_AWIDTH'(8);
    endfunction
`endif

    // Access sequencer: all outputs are registered
    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            state            <= ST_IDLE;
            is_write         <= 1'b0;
            tcnt             <= '0;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_invalid      <= 1'b0;
            rsp_timeout      <= 1'b0;
            rf_address       <= '0;
            rf_read_en       <= 1'b0;
            rf_write_en      <= 1'b0;
            rf_write_data    <= '0;
            stat_timeout_cnt <= '0;
            stat_invalid_cnt <= '0;
        end else begin
            // strobes are single-cycle pulses
            rf_read_en  <= 1'b0;
            rf_write_en <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rf_address    <= req_addr;
                        rf_write_data <= req_wdata;
                        is_write      <= req_write;
                        req_ready     <= 1'b0;
`ifdef OPENHMC_RF_MASTER_ADDR_CHECK_EN
                        if (addr_rejected(req_write, req_addr)) begin
                            rsp_valid        <= 1'b1;
                            rsp_invalid      <= 1'b1;
                            rsp_timeout      <= 1'b0;
                            rsp_rdata        <= '0;
                            stat_invalid_cnt <= sat_inc(stat_invalid_cnt);
                            state            <= ST_RESP;
                        end else begin
                            rf_write_en <= req_write;
                            rf_read_en  <= !req_write;
                            state       <= ST_ISSUE;
                        end
`else
                        rf_write_en <= req_write;
                        rf_read_en  <= !req_write;
                        state       <= ST_ISSUE;
`endif
                    end
                end

                // Strobe cycle; a completion seen here belongs to nothing and is ignored
                ST_ISSUE: begin
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end

                // Completion has priority over timeout in the same cycle
                ST_WAIT: begin
                    if (rf_access_complete) begin
                        rsp_valid   <= 1'b1;
                        rsp_invalid <= rf_invalid_address;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (is_write || rf_invalid_address) ? '0 : rf_read_data;
                        if (rf_invalid_address)
                            stat_invalid_cnt <= sat_inc(stat_invalid_cnt);
                        state <= ST_RESP;
                    end else if (tcnt == TCNT_LAST) begin
                        rsp_valid        <= 1'b1;
                        rsp_invalid      <= 1'b0;
                        rsp_timeout      <= 1'b1;
                        rsp_rdata        <= '0;
                        stat_timeout_cnt <= sat_inc(stat_timeout_cnt);
                        state            <= ST_RESP;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end

                // Payload is held until consumed; late RF completions are ignored
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_openhmc_rf_master.sv
// -----------------------------------------------------------------------------
// tb_openhmc_rf_master
// Self-checking bench for openhmc_rf_master. Two instances are built: one with
// the default timeout (index 0) and one with TIMEOUT_CYCLES = 4 (index 1).
// 'cur' selects which instance receives command/response handshakes; the RF
// side inputs are shared (an idle instance ignores them).
// Expected responses are computed per transaction from the access rules:
// the RF completes 'lat' cycles after the strobe, the access times out when
// lat exceeds the timeout, and the response appears one cycle after the
// completion (or after the last wait cycle on timeout).
// -----------------------------------------------------------------------------
module tb_openhmc_rf_master;

    localparam int unsigned AW = 4;
    localparam int unsigned WW = 64;
    localparam int unsigned RW = 64;

    logic          clk_hmc = 1'b0;
    logic          res_n_hmc;
    logic          cur;
    logic          req_valid, req_write, rsp_ready;
    logic [AW-1:0] req_addr;
    logic [WW-1:0] req_wdata;
    logic [RW-1:0] rf_read_data;
    logic          rf_invalid_address, rf_access_complete;

    logic          req_valid_d [2];
    logic          rsp_ready_d [2];
    logic          req_ready_d [2];
    logic          rsp_valid_d [2];
    logic [RW-1:0] rsp_rdata_d [2];
    logic          rsp_invalid_d [2];
    logic          rsp_timeout_d [2];
    logic [AW-1:0] rf_address_d [2];
    logic          rf_read_en_d [2];
    logic          rf_write_en_d [2];
    logic [WW-1:0] rf_write_data_d [2];
    logic [7:0]    stat_to_d [2];
    logic [7:0]    stat_inv_d [2];

    int nvec = 0;
    int nerr = 0;
    int exp_to [2];
    int exp_inv [2];

    always #5 clk_hmc = ~clk_hmc;

    assign req_valid_d[0] = req_valid & ~cur;
    assign req_valid_d[1] = req_valid & cur;
    assign rsp_ready_d[0] = rsp_ready & ~cur;
    assign rsp_ready_d[1] = rsp_ready & cur;

    openhmc_rf_master #(
        .HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW), .HMC_RF_RWIDTH(RW), .TIMEOUT_CYCLES(256)
    ) u_dut (
        .clk_hmc(clk_hmc), .res_n_hmc(res_n_hmc),
        .req_valid(req_valid_d[0]), .req_ready(req_ready_d[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_d[0]), .rsp_ready(rsp_ready_d[0]), .rsp_rdata(rsp_rdata_d[0]),
        .rsp_invalid(rsp_invalid_d[0]), .rsp_timeout(rsp_timeout_d[0]),
        .rf_address(rf_address_d[0]), .rf_read_en(rf_read_en_d[0]),
        .rf_write_en(rf_write_en_d[0]), .rf_write_data(rf_write_data_d[0]),
        .rf_read_data(rf_read_data), .rf_invalid_address(rf_invalid_address),
        .rf_access_complete(rf_access_complete),
        .stat_timeout_cnt(stat_to_d[0]), .stat_invalid_cnt(stat_inv_d[0])
    );

    openhmc_rf_master #(
        .HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW), .HMC_RF_RWIDTH(RW), .TIMEOUT_CYCLES(4)
    ) u_dut_t4 (
        .clk_hmc(clk_hmc), .res_n_hmc(res_n_hmc),
        .req_valid(req_valid_d[1]), .req_ready(req_ready_d[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_d[1]), .rsp_ready(rsp_ready_d[1]), .rsp_rdata(rsp_rdata_d[1]),
        .rsp_invalid(rsp_invalid_d[1]), .rsp_timeout(rsp_timeout_d[1]),
        .rf_address(rf_address_d[1]), .rf_read_en(rf_read_en_d[1]),
        .rf_write_en(rf_write_en_d[1]), .rf_write_data(rf_write_data_d[1]),
        .rf_read_data(rf_read_data), .rf_invalid_address(rf_invalid_address),
        .rf_access_complete(rf_access_complete),
        .stat_timeout_cnt(stat_to_d[1]), .stat_invalid_cnt(stat_inv_d[1])
    );

    task automatic step();
        @(posedge clk_hmc);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // One complete access on instance 'cur', checked cycle by cycle.
    // lat: cycles from strobe to RF completion (larger than the timeout = never).
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [WW-1:0] wdata,
                           input int lat, input logic [RW-1:0] rd, input bit rinv,
                           input int hold, input bit keep_valid, input bit glitch,
                           input bit late, input string tag);
        int            tmo;
        int            nw;
        int            n;
        bit            rej;
        bit            e_to, e_inv;
        logic [RW-1:0] e_rd;
        logic [RW+2:0] e_rsp;
        tmo = cur ? 4 : 256;
        rej = 1'b0;
`ifdef OPENHMC_RF_MASTER_ADDR_CHECK_EN
        rej = wr ? ((addr <= 4'hC) && (addr != 4'h2) && (addr != 4'h8)) : (addr == 4'h8);
`endif
        if (rej) begin
            e_to = 1'b0; e_inv = 1'b1; e_rd = '0;
        end else begin
            e_to  = lat > tmo;
            e_inv = !e_to && rinv;
            e_rd  = (e_to || e_inv || wr) ? '0 : rd;
        end
        e_rsp = {1'b1, e_inv, e_to, e_rd};

        n = 0;
        while (req_ready_d[cur] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        nvec++;
        if (req_ready_d[cur] !== 1'b1) begin
            nerr++;
            $display("FAIL %s ready_wait: req_ready=%b required 1", tag, req_ready_d[cur]);
            return;
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        rf_access_complete = 1'b0;
        step();
        req_valid = 1'b0;

        if (!rej) begin
            // strobe cycle
            nvec++;
            if ({rf_write_en_d[cur], rf_read_en_d[cur], rsp_valid_d[cur], rf_address_d[cur],
                 rf_write_data_d[cur]} !== {wr, !wr, 1'b0, addr, wdata}) begin
                nerr++;
                $display("FAIL %s strobe: we=%b re=%b rv=%b addr=%h wd=%h required we=%b re=%b rv=0 addr=%h wd=%h",
                         tag, rf_write_en_d[cur], rf_read_en_d[cur], rsp_valid_d[cur],
                         rf_address_d[cur], rf_write_data_d[cur], wr, !wr, addr, wdata);
            end
            rf_access_complete = glitch;
            rf_invalid_address = 1'($urandom);
            rf_read_data       = {$urandom, $urandom};
            step();
            nw = e_to ? tmo : lat;
            for (int j = 1; j <= nw; j++) begin
                nvec++;
                if ({rf_write_en_d[cur], rf_read_en_d[cur], rsp_valid_d[cur], rf_address_d[cur],
                     rf_write_data_d[cur]} !== {3'b000, addr, wdata}) begin
                    nerr++;
                    $display("FAIL %s wait%0d: we=%b re=%b rv=%b addr=%h required 0 0 0 addr=%h",
                             tag, j, rf_write_en_d[cur], rf_read_en_d[cur], rsp_valid_d[cur],
                             rf_address_d[cur], addr);
                end
                rf_access_complete = (j == lat);
                rf_read_data       = (j == lat) ? rd : {$urandom, $urandom};
                rf_invalid_address = (j == lat) ? rinv : 1'($urandom);
                step();
            end
        end

        if (e_inv) exp_inv[cur] = sat(exp_inv[cur]);
        if (e_to)  exp_to[cur]  = sat(exp_to[cur]);
        rf_access_complete = late;
        rf_invalid_address = 1'b1;
        rf_read_data       = {$urandom, $urandom};

        nvec++;
        if ({rsp_valid_d[cur], rsp_invalid_d[cur], rsp_timeout_d[cur], rsp_rdata_d[cur]} !== e_rsp) begin
            nerr++;
            $display("FAIL %s resp: v/i/t/rd=%b%b%b %h required %b%b%b %h", tag,
                     rsp_valid_d[cur], rsp_invalid_d[cur], rsp_timeout_d[cur], rsp_rdata_d[cur],
                     1'b1, e_inv, e_to, e_rd);
        end
        nvec++;
        if ({stat_to_d[cur], stat_inv_d[cur], rf_write_en_d[cur], rf_read_en_d[cur], req_ready_d[cur]}
            !== {8'(exp_to[cur]), 8'(exp_inv[cur]), 3'b000}) begin
            nerr++;
            $display("FAIL %s stats: to=%0d inv=%0d we=%b re=%b rdy=%b required to=%0d inv=%0d 0 0 0",
                     tag, stat_to_d[cur], stat_inv_d[cur], rf_write_en_d[cur], rf_read_en_d[cur],
                     req_ready_d[cur], exp_to[cur], exp_inv[cur]);
        end

        for (int h = 0; h < hold; h++) begin
            if (keep_valid) req_valid = 1'b1;
            rsp_ready = 1'b0;
            step();
            rf_access_complete = 1'b0;
            nvec++;
            if ({rsp_valid_d[cur], rsp_invalid_d[cur], rsp_timeout_d[cur], rsp_rdata_d[cur],
                 req_ready_d[cur], rf_address_d[cur]} !== {e_rsp, 1'b0, addr}) begin
                nerr++;
                $display("FAIL %s hold%0d: v/i/t/rd=%b%b%b %h rdy=%b addr=%h required %b %h rdy=0 addr=%h",
                         tag, h, rsp_valid_d[cur], rsp_invalid_d[cur], rsp_timeout_d[cur],
                         rsp_rdata_d[cur], req_ready_d[cur], rf_address_d[cur],
                         e_rsp[RW+2:RW], e_rd, addr);
            end
        end

        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        rf_access_complete = 1'b0;
        nvec++;
        if ({rsp_valid_d[cur], req_ready_d[cur]} !== 2'b01) begin
            nerr++;
            $display("FAIL %s release: rsp_valid=%b req_ready=%b required 0 1",
                     tag, rsp_valid_d[cur], req_ready_d[cur]);
        end
    endtask

    task automatic test_reset();
        res_n_hmc = 1'b0;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if ({req_ready_d[d], rsp_valid_d[d], rsp_invalid_d[d], rsp_timeout_d[d], rsp_rdata_d[d],
                 rf_read_en_d[d], rf_write_en_d[d], rf_address_d[d], rf_write_data_d[d],
                 stat_to_d[d], stat_inv_d[d]} !== {1'b1, {(5 + RW + AW + WW + 16){1'b0}}}) begin
                nerr++;
                $display("FAIL reset%0d: rdy=%b rv=%b re=%b we=%b to=%0d inv=%0d required 1 0 0 0 0 0",
                         d, req_ready_d[d], rsp_valid_d[d], rf_read_en_d[d], rf_write_en_d[d],
                         stat_to_d[d], stat_inv_d[d]);
            end
        end
        res_n_hmc = 1'b1;
        step();
    endtask

    task automatic test_write_basic();
        cur = 1'b0;
        run_txn(1'b1, 4'h2, 64'hDEADBEEF_00000001, 1, 64'hFFFF_0000_1111_2222, 1'b0, 0, 1'b0,
                1'b0, 1'b0, "write_basic");
    endtask

    task automatic test_read_slow();
        cur = 1'b0;
        run_txn(1'b0, 4'h0, 64'h55AA_55AA_55AA_55AA, 5, 64'h123, 1'b0, 2, 1'b0, 1'b1, 1'b1,
                "read_slow");
    endtask

    task automatic test_invalid();
        cur = 1'b0;
        run_txn(1'b0, 4'h8, 64'h0, 2, 64'hABCD, 1'b1, 1, 1'b0, 1'b0, 1'b0, "read_invalid");
        nvec++;
        if (stat_inv_d[0] !== 8'd1) begin
            nerr++;
            $display("FAIL invalid_cnt: stat_invalid_cnt=%0d required 1", stat_inv_d[0]);
        end
    endtask

    task automatic test_timeout();
        cur = 1'b1;
        run_txn(1'b0, 4'h3, 64'h0, 1000, 64'h777, 1'b0, 3, 1'b0, 1'b0, 1'b1, "timeout_t4");
        nvec++;
        if (stat_to_d[1] !== 8'd1) begin
            nerr++;
            $display("FAIL timeout_cnt: stat_timeout_cnt=%0d required 1", stat_to_d[1]);
        end
        run_txn(1'b0, 4'h4, 64'h0, 4, 64'h444, 1'b0, 0, 1'b0, 1'b0, 1'b0, "complete_at_limit");
        run_txn(1'b1, 4'h2, 64'h9, 5, 64'h555, 1'b0, 0, 1'b0, 1'b0, 1'b0, "timeout_by_one");
        cur = 1'b0;
        run_txn(1'b0, 4'h1, 64'h0, 256, 64'h256, 1'b0, 0, 1'b0, 1'b0, 1'b0, "complete_at_256");
        run_txn(1'b0, 4'h1, 64'h0, 257, 64'h257, 1'b0, 0, 1'b0, 1'b0, 1'b1, "timeout_256");
    endtask

    task automatic test_back_to_back();
        cur = 1'b0;
        run_txn(1'b0, 4'h5, 64'h1, 2, 64'hCAFE, 1'b0, 10, 1'b1, 1'b0, 1'b0, "b2b_first");
        run_txn(1'b1, 4'hD, 64'h2222, 1, 64'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            cur = 1'($urandom);
            run_txn(1'($urandom), 4'($urandom), {$urandom, $urandom}, int'($urandom_range(1, 7)),
                    {$urandom, $urandom}, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                    1'b0, 1'($urandom), 1'($urandom), "random");
        end
    endtask

    // Drive the invalid counter of instance 0 past 255
    task automatic test_saturation();
        cur = 1'b0;
        for (int i = 0; i < 260; i++) begin
            run_txn(1'b0, 4'($urandom_range(0, 7)), 64'h0, 1, 64'h1, 1'b1, 0, 1'b0, 1'b0, 1'b0,
                    "saturate");
        end
        nvec++;
        if (stat_inv_d[0] !== 8'd255) begin
            nerr++;
            $display("FAIL saturate_final: stat_invalid_cnt=%0d required 255", stat_inv_d[0]);
        end
    endtask

    task automatic test_reset_mid();
        cur = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h6; req_wdata = 64'h0;
        step();
        req_valid = 1'b0;
        step();
        step();
        #2;
        res_n_hmc = 1'b0;
        #1;
        exp_to[0] = 0; exp_to[1] = 0; exp_inv[0] = 0; exp_inv[1] = 0;
        for (int d = 0; d < 2; d++) begin
            nvec++;
            if ({rf_read_en_d[d], rf_write_en_d[d], rsp_valid_d[d], req_ready_d[d], stat_to_d[d],
                 stat_inv_d[d]} !== {4'b0001, 16'h0}) begin
                nerr++;
                $display("FAIL reset_mid%0d: re=%b we=%b rv=%b rdy=%b to=%0d inv=%0d required 0 0 0 1 0 0",
                         d, rf_read_en_d[d], rf_write_en_d[d], rsp_valid_d[d], req_ready_d[d],
                         stat_to_d[d], stat_inv_d[d]);
            end
        end
        step();
        res_n_hmc = 1'b1;
        repeat (3) step();
        nvec++;
        if ({rsp_valid_d[0], req_ready_d[0], stat_to_d[0], stat_inv_d[0]} !== {2'b01, 16'h0}) begin
            nerr++;
            $display("FAIL reset_mid_release: rv=%b rdy=%b to=%0d inv=%0d required 0 1 0 0",
                     rsp_valid_d[0], req_ready_d[0], stat_to_d[0], stat_inv_d[0]);
        end
        run_txn(1'b0, 4'h0, 64'h0, 3, 64'hBEEF, 1'b0, 0, 1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        cur = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        rf_read_data = '0; rf_invalid_address = 1'b0; rf_access_complete = 1'b0;
        exp_to[0] = 0; exp_to[1] = 0; exp_inv[0] = 0; exp_inv[1] = 0;
        test_reset();
        test_write_basic();
        test_read_slow();
        test_invalid();
        test_timeout();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
